// File: rtl/code_converter_pipe.sv
// Two-stage valid/ready code converter: binary<->Gray, BCD<->Excess-3 per word.
// Optional saturating error counter on err_count when CODE_CONV_ERRCNT_EN is defined.
module code_converter_pipe #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_mode,
  output logic         out_err
`ifdef CODE_CONV_ERRCNT_EN
  ,
  output logic [15:0]  err_count
`endif
);

  localparam int NIB = W / 4;

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_data_q, s1_data_d;
  logic [1:0]   s1_mode_q, s1_mode_d;
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] s2_data_q, s2_data_d;
  logic [1:0]   s2_mode_q, s2_mode_d;
  logic         s2_err_q, s2_err_d;
  logic         s1_ready_s;
  logic         s2_ready_s;
  logic [W-1:0] conv_data_s;
  logic         conv_err_s;

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ {1'b0, b[W-1:1]};
  endfunction

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] r;
    r[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

  // Result in [W-1:0], error flag in [W]
  function automatic logic [W:0] bcd2xs3(input logic [W-1:0] d);
    logic [W:0] r;
    logic [3:0] nib;
    r = '0;
    for (int n = 0; n < NIB; n++) begin
      nib        = d[4*n +: 4];
      r[4*n +: 4] = nib + 4'd3;
      if (nib > 4'd9) begin
        r[W] = 1'b1;
      end else begin
        r[W] = r[W];
      end
    end
    return r;
  endfunction

  function automatic logic [W:0] xs32bcd(input logic [W-1:0] d);
    logic [W:0] r;
    logic [3:0] nib;
    r = '0;
    for (int n = 0; n < NIB; n++) begin
      nib        = d[4*n +: 4];
      r[4*n +: 4] = nib - 4'd3;
      if ((nib < 4'd3) || (nib > 4'd12)) begin
        r[W] = 1'b1;
      end else begin
        r[W] = r[W];
      end
    end
    return r;
  endfunction

  // Ready chain: depends only on registered valids and out_ready
  always_comb begin
    s2_ready_s = !s2_valid_q || out_ready;
    s1_ready_s = !s1_valid_q || s2_ready_s;
  end

  assign in_ready  = s1_ready_s;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_mode  = s2_mode_q;
  assign out_err   = s2_err_q;

  // Conversion of the word held in S1
  always_comb begin
    logic [W:0] tmp;
    tmp         = '0;
    conv_data_s = '0;
    conv_err_s  = 1'b0;
    case (s1_mode_q)
      2'b00: conv_data_s = bin2gray(s1_data_q);
      2'b01: conv_data_s = gray2bin(s1_data_q);
      2'b10: begin
        tmp         = bcd2xs3(s1_data_q);
        conv_data_s = tmp[W-1:0];
        conv_err_s  = tmp[W];
      end
      2'b11: begin
        tmp         = xs32bcd(s1_data_q);
        conv_data_s = tmp[W-1:0];
        conv_err_s  = tmp[W];
      end
      default: begin
        conv_data_s = '0;
        conv_err_s  = 1'b0;
      end
    endcase
  end

  // S1 next state: load from input when it can move
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    if (s1_ready_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_mode_d = in_mode;
      end else begin
        s1_data_d = s1_data_q;
        s1_mode_d = s1_mode_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S2 next state: capture converted S1 word when the output can move
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_mode_d  = s2_mode_q;
    s2_err_d   = s2_err_q;
    if (s2_ready_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = conv_data_s;
        s2_mode_d = s1_mode_q;
        s2_err_d  = conv_err_s;
      end else begin
        s2_data_d = s2_data_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 2'b00;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_mode_q  <= 2'b00;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_mode_q  <= s2_mode_d;
      s2_err_q   <= s2_err_d;
    end
  end

`ifdef CODE_CONV_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count delivered error words, saturating
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_code_converter_pipe.sv
// Scoreboard bench for code_converter_pipe (W=8): stimulus pushes expected words,
// a monitor pops and compares on every output transfer.
module tb_code_converter_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_mode;
  logic       out_err;
`ifdef CODE_CONV_ERRCNT_EN
  logic [15:0] err_count;
`endif

  code_converter_pipe #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_err   (out_err)
`ifdef CODE_CONV_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] m;
    logic       e;
    bit         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_acc = 0;

  logic [7:0] gtab [16] = '{8'h0, 8'h1, 8'h3, 8'h2, 8'h6, 8'h7, 8'h5, 8'h4,
                            8'hC, 8'hD, 8'hF, 8'hE, 8'hA, 8'hB, 8'h9, 8'h8};

  // Directed BCD/XS3/Gray vectors: input, mode, expected data, expected err
  logic [7:0] v_in  [10] = '{8'h59, 8'h5A, 8'h8C, 8'h22, 8'h99, 8'hD0, 8'h33, 8'hCC, 8'hFF, 8'h80};
  logic [1:0] v_md  [10] = '{2'd2,  2'd2,  2'd3,  2'd3,  2'd2,  2'd3,  2'd3,  2'd3,  2'd0,  2'd1};
  logic [7:0] v_out [10] = '{8'h8C, 8'h8D, 8'h59, 8'hFF, 8'hCC, 8'hAD, 8'h00, 8'h99, 8'h80, 8'hFF};
  logic       v_err [10] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] m,
                      input logic [7:0] xd, input logic xe, input bit lat);
    exp_t e;
    bit   ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.d = xd; e.m = m; e.e = xe; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
        n_acc++;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk("drain_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every output transfer and stall stability
  initial begin
    exp_t       e;
    bit         held_v;
    logic [7:0] held_d;
    logic [1:0] held_m;
    logic       held_e;
    held_v = 1'b0;
    held_d = 8'h0;
    held_m = 2'b00;
    held_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v && out_valid) begin
          chk("stall_stable", {out_err, out_mode, out_data}, {held_e, held_m, held_d});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", {out_err, out_mode, out_data}, 32'hDEAD);
          end else begin
            e = sb.pop_front();
            chk("out_word", {out_err, out_mode, out_data}, {e.e, e.m, e.d});
            if (e.lat) chk("latency", cyc - e.acc, 32'd2);
          end
        end
        held_v = out_valid && !out_ready;
        held_d = out_data;
        held_m = out_mode;
        held_e = out_err;
      end
    end
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_mode_err", {out_mode, out_err}, 32'd0);
    chk("rst_in_ready", in_ready, 32'd1);
`ifdef CODE_CONV_ERRCNT_EN
    chk("rst_err_count", err_count, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Binary -> Gray, back-to-back
    for (int i = 0; i < 16; i++) send(i[7:0], 2'd0, gtab[i], 1'b0, 1'b1);
    drain();
    // Gray -> binary
    for (int i = 0; i < 16; i++) send(gtab[i], 2'd1, i[7:0], 1'b0, 1'b1);
    drain();
    // BCD/XS3 and wide Gray boundary vectors
    for (int i = 0; i < 10; i++) send(v_in[i], v_md[i], v_out[i], v_err[i], 1'b1);
    drain();

    // Backpressure: 5 words, output stalled for 4 cycles
    base = n_acc;
    fork
      begin
        send(8'h10, 2'd0, 8'h18, 1'b0, 1'b0);
        send(8'h20, 2'd0, 8'h30, 1'b0, 1'b0);
        send(8'h12, 2'd2, 8'h45, 1'b0, 1'b0);
        send(8'h8C, 2'd3, 8'h59, 1'b0, 1'b0);
        send(8'hA5, 2'd0, 8'hF7, 1'b0, 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 32'd0);
        chk("bp_accepts", n_acc - base, 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two words in flight
    send(8'h01, 2'd0, 8'h01, 1'b0, 1'b1);
    send(8'h02, 2'd0, 8'h03, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h07, 2'd0, 8'h04, 1'b0, 1'b1);
    drain();

`ifdef CODE_CONV_ERRCNT_EN
    send(8'hA0, 2'd2, 8'hD3, 1'b1, 1'b1);
    send(8'hA0, 2'd2, 8'hD3, 1'b1, 1'b1);
    drain();
    chk("errcnt_2", err_count, 32'd2);
    out_ready = 1'b0;
    send(8'hA0, 2'd2, 8'hD3, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("errcnt_stalled", err_count, 32'd2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    chk("errcnt_3", err_count, 32'd3);
    for (int i = 0; i < 65537; i++) send(8'hA0, 2'd2, 8'hD3, 1'b1, 1'b1);
    drain();
    chk("errcnt_sat", err_count, 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
